// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared widths, field moduli and helpers for the alarm-clock datapath
package alarm_pkg;

  localparam int DIGIT_W = 4;

  // Moduli of the individual clock fields
  localparam int SEC_LO = 10;
  localparam int SEC_HI = 6;
  localparam int HR_HI  = 3;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_LOAD = 2'd2
  } next_sel_e;

  function automatic bit modulus_ok(input int width, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/mod_incr.sv
// rtl/mod_incr.sv - combinational modulo incrementer with at-max flag
module mod_incr
  import alarm_pkg::*;
#(
  parameter int WIDTH   = DIGIT_W,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  assign at_max = (value == MAX_VAL);
  assign next   = at_max ? '0 : value + WIDTH'(1);

endmodule

// File: rtl/reg_4bit.sv
// rtl/reg_4bit.sv - loadable modulo-counting digit register with cascade wrap output
module reg_4bit
  import alarm_pkg::*;
#(
  parameter int WIDTH   = DIGIT_W,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] Q,
  output logic             wrap
);

  generate
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("reg_4bit: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  next_sel_e        sel;
  logic [WIDTH-1:0] incr_q;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] next_q;
  logic             at_max;

  mod_incr #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_incr (
    .value  (Q),
    .next   (incr_q),
    .at_max (at_max)
  );

  // Out-of-range loads collapse to 0 so Q never leaves 0..MODULUS-1
  assign load_q = ({1'b0, D} < MOD_EXT) ? D : '0;

  always_comb begin
    sel = SEL_HOLD;
    if (load) begin
      sel = SEL_LOAD;
    end else if (inc) begin
      sel = SEL_INC;
    end
  end

  always_comb begin
    next_q = Q;
    case (sel)
      SEL_LOAD: next_q = load_q;
      SEL_INC:  next_q = incr_q;
      default:  next_q = Q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q <= '0;
    end else begin
      Q <= next_q;
    end
  end

  assign wrap = rst_n & inc & ~load & at_max;

endmodule

// File: tb/tb_reg_4bit.sv
// tb/tb_reg_4bit.sv - directed self-checking bench for reg_4bit at MODULUS 16 and 10
module tb_reg_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] D = 4'h0;
  logic       load = 1'b0;
  logic       inc = 1'b0;
  logic [3:0] q16;
  logic       wrap16;
  logic [3:0] q10;
  logic       wrap10;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_4bit #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .load  (load),
    .inc   (inc),
    .Q     (q16),
    .wrap  (wrap16)
  );

  reg_4bit #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .load  (load),
    .inc   (inc),
    .Q     (q10),
    .wrap  (wrap10)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load = 1'b1;
    D = 4'h9;
    #1;
    checks++;
    if (q16 !== 4'h0) begin
      failures++;
      $display("FAIL reset_immediate q=%0h exp=0", q16);
    end
    checks++;
    if (wrap16 !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrap wrap=%0b exp=0", wrap16);
    end
    step();
    step();
    checks++;
    if (q16 !== 4'h0 || q10 !== 4'h0) begin
      failures++;
      $display("FAIL reset_held q16=%0h q10=%0h exp=0", q16, q10);
    end
    rst_n = 1'b1;
    load = 1'b0;
    D = 4'h0;
  endtask

  task automatic test_load_count();
    load = 1'b1;
    D = 4'h0;
    step();
    load = 1'b0;
    inc = 1'b1;
    step();
    checks++;
    if (q16 !== 4'h1) begin
      failures++;
      $display("FAIL count_edge1 q=%0h exp=1", q16);
    end
    step();
    checks++;
    if (q16 !== 4'h2) begin
      failures++;
      $display("FAIL count_edge2 q=%0h exp=2", q16);
    end
    inc = 1'b0;
  endtask

  task automatic test_wrap16();
    load = 1'b1;
    D = 4'hF;
    step();
    checks++;
    if (q16 !== 4'hF) begin
      failures++;
      $display("FAIL wrap16_load q=%0h exp=f", q16);
    end
    load = 1'b0;
    inc = 1'b1;
    #1;
    checks++;
    if (wrap16 !== 1'b1) begin
      failures++;
      $display("FAIL wrap16_before wrap=%0b exp=1", wrap16);
    end
    step();
    checks++;
    if (q16 !== 4'h0 || wrap16 !== 1'b0) begin
      failures++;
      $display("FAIL wrap16_after q=%0h wrap=%0b exp q=0 wrap=0", q16, wrap16);
    end
    inc = 1'b0;
  endtask

  task automatic test_wrap10();
    load = 1'b1;
    D = 4'h9;
    step();
    load = 1'b0;
    inc = 1'b1;
    #1;
    checks++;
    if (q10 !== 4'h9 || wrap10 !== 1'b1) begin
      failures++;
      $display("FAIL wrap10_before q=%0h wrap=%0b exp q=9 wrap=1", q10, wrap10);
    end
    step();
    checks++;
    if (q10 !== 4'h0) begin
      failures++;
      $display("FAIL wrap10_after q=%0h exp=0", q10);
    end
    inc = 1'b0;
  endtask

  task automatic test_count10_sequence();
    logic [3:0] exp;
    load = 1'b1;
    D = 4'h0;
    step();
    load = 1'b0;
    inc = 1'b1;
    exp = 4'h0;
    for (int i = 0; i < 12; i++) begin
      exp = (exp == 4'h9) ? 4'h0 : exp + 4'h1;
      step();
      checks++;
      if (q10 !== exp) begin
        failures++;
        $display("FAIL count10_seq step=%0d q=%0h exp=%0h", i, q10, exp);
      end
    end
    inc = 1'b0;
  endtask

  task automatic test_priority_hold();
    load = 1'b1;
    D = 4'hF;
    step();
    inc = 1'b1;
    D = 4'h3;
    #1;
    checks++;
    if (wrap16 !== 1'b0) begin
      failures++;
      $display("FAIL prio_wrap wrap=%0b exp=0", wrap16);
    end
    step();
    checks++;
    if (q16 !== 4'h3) begin
      failures++;
      $display("FAIL prio_load q=%0h exp=3", q16);
    end
    load = 1'b0;
    inc = 1'b0;
    D = 4'hA;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q16 !== 4'h3) begin
        failures++;
        $display("FAIL hold step=%0d q=%0h exp=3", i, q16);
      end
    end
  endtask

  task automatic test_range();
    load = 1'b1;
    D = 4'hC;
    step();
    checks++;
    if (q10 !== 4'h0) begin
      failures++;
      $display("FAIL range10 q=%0h exp=0", q10);
    end
    checks++;
    if (q16 !== 4'hC) begin
      failures++;
      $display("FAIL range16 q=%0h exp=c", q16);
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1;
    D = 4'h7;
    step();
    load = 1'b0;
    inc = 1'b0;
    checks++;
    if (q16 !== 4'h7) begin
      failures++;
      $display("FAIL async_pre q=%0h exp=7", q16);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q16 !== 4'h0 || wrap16 !== 1'b0) begin
      failures++;
      $display("FAIL async_drop q=%0h wrap=%0b exp q=0 wrap=0", q16, wrap16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    inc = 1'b1;
    step();
    checks++;
    if (q16 !== 4'h1) begin
      failures++;
      $display("FAIL async_release q=%0h exp=1", q16);
    end
    inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_count();
    test_wrap16();
    test_wrap10();
    test_count10_sequence();
    test_priority_hold();
    test_range();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
